// File: rtl/mem8x8_pkg.sv
// Shared constants and types for the 8x8 memory array arbiter.
package mem8x8_pkg;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StDone   = 2'd2
   } state_e;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester combinational grant. Round-robin on the last-grant pointer by
// default; MEM8X8_ARB_FIXED_PRIO_EN selects fixed priority with port A first.
module rr_arb2 (
   input  logic req_a,
   input  logic req_b,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant
);
   import mem8x8_pkg::*;

`ifdef MEM8X8_ARB_FIXED_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      grant_valid = req_a | req_b;
      grant       = req_a ? PORT_A : PORT_B;
   end
`else
   always_comb begin
      grant_valid = req_a | req_b;
      if (req_a && req_b) begin
         grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
      end else begin
         grant = req_a ? PORT_A : PORT_B;
      end
   end
`endif

endmodule

// File: rtl/mem8x8_arbiter.sv
// Two-port arbitrated access controller for the 8x8 bitcell array.
// Define MEM8X8_ARB_FIXED_PRIO_EN for fixed port-A priority instead of round-robin.
module mem8x8_arbiter #(
   parameter int unsigned ADDR_W = mem8x8_pkg::ADDR_W,
   parameter int unsigned DATA_W = mem8x8_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_select,
   output logic              mem_rw,
   input  logic [DATA_W-1:0] mem_data_out
);
   import mem8x8_pkg::*;

   state_e state;
   logic   grant_q;
   logic   last_grant;
   logic   grant_valid;
   logic   grant;

`ifdef MEM8X8_ARB_FIXED_PRIO_EN
   assign last_grant = PORT_B;
`endif

   rr_arb2 u_arb (
      .req_a       (a_req),
      .req_b       (b_req),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // mem_rw/mem_address/mem_data_in double as the command register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StIdle;
         grant_q     <= PORT_A;
         mem_select  <= 1'b0;
         mem_rw      <= 1'b0;
         mem_address <= '0;
         mem_data_in <= '0;
         a_ack       <= 1'b0;
         b_ack       <= 1'b0;
         a_rdata     <= '0;
         b_rdata     <= '0;
`ifndef MEM8X8_ARB_FIXED_PRIO_EN
         last_grant  <= PORT_B;
`endif
      end else begin
         case (state)
            StIdle: begin
               if (grant_valid) begin
                  grant_q     <= grant;
                  mem_rw      <= (grant == PORT_A) ? a_we    : b_we;
                  mem_address <= (grant == PORT_A) ? a_addr  : b_addr;
                  mem_data_in <= (grant == PORT_A) ? a_wdata : b_wdata;
                  mem_select  <= 1'b1;
                  state       <= StAccess;
               end
            end
            StAccess: begin
               if (!mem_rw) begin
                  if (grant_q == PORT_A) begin
                     a_rdata <= mem_data_out;
                  end else begin
                     b_rdata <= mem_data_out;
                  end
               end
               mem_select <= 1'b0;
               a_ack      <= (grant_q == PORT_A);
               b_ack      <= (grant_q == PORT_B);
               state      <= StDone;
            end
            StDone: begin
               a_ack      <= 1'b0;
               b_ack      <= 1'b0;
`ifndef MEM8X8_ARB_FIXED_PRIO_EN
               last_grant <= grant_q;
`endif
               state      <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem8x8_arbiter.sv
// Directed bench for mem8x8_arbiter with a behavioural 8x8 array model.
module tb_mem8x8_arbiter;

   logic       clk;
   logic       rst_n;
   logic       a_req, a_we, b_req, b_we;
   logic [2:0] a_addr, b_addr;
   logic [7:0] a_wdata, b_wdata;
   logic       a_ack, b_ack;
   logic [7:0] a_rdata, b_rdata;
   logic [2:0] mem_address;
   logic [7:0] mem_data_in;
   logic       mem_select, mem_rw;
   logic [7:0] mem_data_out;

   logic [7:0] mem [8];

   int n_cmp = 0;
   int n_bad = 0;

   mem8x8_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a_req        (a_req),
      .a_we         (a_we),
      .a_addr       (a_addr),
      .a_wdata      (a_wdata),
      .a_ack        (a_ack),
      .a_rdata      (a_rdata),
      .b_req        (b_req),
      .b_we         (b_we),
      .b_addr       (b_addr),
      .b_wdata      (b_wdata),
      .b_ack        (b_ack),
      .b_rdata      (b_rdata),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_select   (mem_select),
      .mem_rw       (mem_rw),
      .mem_data_out (mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_select && mem_rw) mem[mem_address] <= mem_data_in;
   end
   assign mem_data_out = mem[mem_address];

   typedef struct {
      logic       a_req, a_we;
      logic [2:0] a_addr;
      logic [7:0] a_wdata;
      logic       b_req, b_we;
      logic [2:0] b_addr;
      logic [7:0] b_wdata;
      logic       e_a_ack, e_b_ack, e_sel, e_rw;
      logic [2:0] e_addr;
      logic [7:0] e_din, e_a_rdata, e_b_rdata;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(input int ar, input int aw, input int aa, input int ad,
                               input int br, input int bw, input int ba, input int bd,
                               input int ea, input int eb, input int es, input int er,
                               input int ead, input int edi, input int ear, input int ebr);
      vec_t v;
      v.a_req = ar[0];   v.a_we = aw[0];   v.a_addr = aa[2:0];   v.a_wdata = ad[7:0];
      v.b_req = br[0];   v.b_we = bw[0];   v.b_addr = ba[2:0];   v.b_wdata = bd[7:0];
      v.e_a_ack = ea[0]; v.e_b_ack = eb[0]; v.e_sel = es[0];   v.e_rw = er[0];
      v.e_addr = ead[2:0]; v.e_din = edi[7:0]; v.e_a_rdata = ear[7:0]; v.e_b_rdata = ebr[7:0];
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
      end
   endtask

   task automatic chk_outs(input int idx, input logic ea, input logic eb, input logic es,
                           input logic er, input logic [2:0] ead, input logic [7:0] edi,
                           input logic [7:0] ear, input logic [7:0] ebr);
      chk("a_ack", idx, 32'(a_ack), 32'(ea));
      chk("b_ack", idx, 32'(b_ack), 32'(eb));
      chk("mem_select", idx, 32'(mem_select), 32'(es));
      chk("mem_rw", idx, 32'(mem_rw), 32'(er));
      chk("mem_address", idx, 32'(mem_address), 32'(ead));
      chk("mem_data_in", idx, 32'(mem_data_in), 32'(edi));
      chk("a_rdata", idx, 32'(a_rdata), 32'(ear));
      chk("b_rdata", idx, 32'(b_rdata), 32'(ebr));
   endtask

   initial begin
      //               A: req we ad  wd     B: req we ad  wd     exp: aa ba sel rw ad din  ard  brd
      vecs[0]  = mk(1, 1, 5, 'hA5, 0, 0, 0, 'h00, 0, 0, 1, 1, 5, 'hA5, 'h00, 'h00);
      vecs[1]  = mk(1, 1, 5, 'hA5, 0, 0, 0, 'h00, 1, 0, 0, 1, 5, 'hA5, 'h00, 'h00);
      vecs[2]  = mk(0, 1, 5, 'hA5, 0, 0, 0, 'h00, 0, 0, 0, 1, 5, 'hA5, 'h00, 'h00);
      vecs[3]  = mk(1, 0, 5, 'h00, 0, 0, 0, 'h00, 0, 0, 1, 0, 5, 'h00, 'h00, 'h00);
      vecs[4]  = mk(1, 0, 5, 'h00, 0, 0, 0, 'h00, 1, 0, 0, 0, 5, 'h00, 'hA5, 'h00);
      vecs[5]  = mk(0, 0, 5, 'h00, 0, 0, 0, 'h00, 0, 0, 0, 0, 5, 'h00, 'hA5, 'h00);
      vecs[6]  = mk(0, 0, 5, 'h00, 1, 1, 0, 'h11, 0, 0, 1, 1, 0, 'h11, 'hA5, 'h00);
      vecs[7]  = mk(0, 0, 5, 'h00, 1, 1, 0, 'h11, 0, 1, 0, 1, 0, 'h11, 'hA5, 'h00);
      vecs[8]  = mk(0, 0, 5, 'h00, 1, 1, 7, 'h77, 0, 0, 0, 1, 0, 'h11, 'hA5, 'h00);
      vecs[9]  = mk(0, 0, 5, 'h00, 1, 1, 7, 'h77, 0, 0, 1, 1, 7, 'h77, 'hA5, 'h00);
      vecs[10] = mk(0, 0, 5, 'h00, 1, 1, 7, 'h77, 0, 1, 0, 1, 7, 'h77, 'hA5, 'h00);
      vecs[11] = mk(0, 0, 5, 'h00, 1, 0, 0, 'h77, 0, 0, 0, 1, 7, 'h77, 'hA5, 'h00);
      vecs[12] = mk(0, 0, 5, 'h00, 1, 0, 0, 'h77, 0, 0, 1, 0, 0, 'h77, 'hA5, 'h00);
      vecs[13] = mk(0, 0, 5, 'h00, 1, 0, 7, 'h77, 0, 1, 0, 0, 0, 'h77, 'hA5, 'h11);
      vecs[14] = mk(0, 0, 5, 'h00, 1, 0, 7, 'h77, 0, 0, 0, 0, 0, 'h77, 'hA5, 'h11);
      vecs[15] = mk(0, 0, 5, 'h00, 1, 0, 7, 'h77, 0, 0, 1, 0, 7, 'h77, 'hA5, 'h11);
      vecs[16] = mk(0, 0, 5, 'h00, 0, 0, 7, 'h77, 0, 1, 0, 0, 7, 'h77, 'hA5, 'h77);
      vecs[17] = mk(0, 0, 5, 'h00, 0, 0, 7, 'h77, 0, 0, 0, 0, 7, 'h77, 'hA5, 'h77);
      // Command hold: a_addr moves to 6 in ACCESS, array still sees 2... address 0 here.
      vecs[18] = mk(1, 0, 0, 'h00, 0, 0, 7, 'h77, 0, 0, 1, 0, 0, 'h00, 'hA5, 'h77);
      vecs[19] = mk(1, 0, 6, 'h00, 0, 0, 7, 'h77, 1, 0, 0, 0, 0, 'h00, 'h11, 'h77);
      vecs[20] = mk(0, 0, 6, 'h00, 0, 0, 7, 'h77, 0, 0, 0, 0, 0, 'h00, 'h11, 'h77);

      rst_n = 1'b0;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      repeat (2) @(negedge clk);
      chk_outs(-1, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00, 8'h00);
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         a_req = vecs[i].a_req; a_we = vecs[i].a_we;
         a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
         b_req = vecs[i].b_req; b_we = vecs[i].b_we;
         b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
         @(posedge clk);
         #1;
         chk_outs(i, vecs[i].e_a_ack, vecs[i].e_b_ack, vecs[i].e_sel, vecs[i].e_rw,
                  vecs[i].e_addr, vecs[i].e_din, vecs[i].e_a_rdata, vecs[i].e_b_rdata);
      end

      // Reset asserted during ACCESS drops select and ack at once.
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 3'd4; a_wdata = 8'h44;
      @(posedge clk);
      #1;
      chk("mid_sel_before", 0, 32'(mem_select), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_sel_async", 0, 32'(mem_select), 32'd0);
      chk("mid_a_ack_async", 0, 32'(a_ack), 32'd0);
      chk("mid_addr_async", 0, 32'(mem_address), 32'd0);
      a_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk_outs(100, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00, 8'h00);

      // Contention from reset: A first, then alternate (fixed priority: A only).
      a_req = 1'b1; a_we = 1'b0; a_addr = 3'd1;
      b_req = 1'b1; b_we = 1'b0; b_addr = 3'd3;
      for (int i = 0; i < 12; i++) begin
         logic win_b;
`ifdef MEM8X8_ARB_FIXED_PRIO_EN
         win_b = 1'b0;
`else
         win_b = ((i / 3) % 2) == 1;
`endif
         @(posedge clk);
         #1;
         chk("cont_a_ack", i, 32'(a_ack), 32'((i % 3 == 1) && !win_b));
         chk("cont_b_ack", i, 32'(b_ack), 32'((i % 3 == 1) && win_b));
         chk("cont_sel", i, 32'(mem_select), 32'(i % 3 == 0));
         if (i % 3 == 0) chk("cont_addr", i, 32'(mem_address), win_b ? 32'd3 : 32'd1);
      end
      @(negedge clk);
      a_req = 1'b0;
      b_req = 1'b0;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem8x8_arbiter.md
# mem8x8_arbiter

Two-port arbitrated access controller for the 8x8 bitcell memory array. Two independent requesters (port A, port B) issue single-word read or write transactions. The block grants one requester at a time and drives the array's address, data_in, select and rw lines for exactly one access cycle. It captures read data and returns a one-cycle acknowledge. It sits directly in front of the memory array and is the only driver of its control lines.

## Interface
Parameters:
- ADDR_W, 3, address width; the array has 2^ADDR_W words.
- DATA_W, 8, word width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low. Deassertion is synchronous to clk.
- a_req  in  1  port A request; held high until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read; sampled with a_req.
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  one-cycle pulse when the port A transaction completes.
- a_rdata  out  DATA_W  port A read data; valid while a_ack is high, held until the next port A read.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the port A signals, for port B.
- mem_address  out  ADDR_W  to the array address.
- mem_data_in  out  DATA_W  to the array data_in.
- mem_select  out  1  to the array select; high only in ACCESS.
- mem_rw  out  1  to the array rw; 1 = write, 0 = read.
- mem_data_out  in  DATA_W  from the array data_out.

## Operation
- FSM states are IDLE, ACCESS and DONE, in a 2-bit encoding.
- IDLE:
  - If neither request is pending, stay in IDLE.
  - Otherwise pick a winner, latch its we/addr/wdata into the command register, record the grant, and go to ACCESS.
- ACCESS (one cycle):
  - mem_select = 1; mem_rw, mem_address and mem_data_in come from the command register.
  - On a read, mem_data_out is captured into the granted port's rdata register at the closing edge.
  - Go to DONE.
- DONE (one cycle):
  - mem_select = 0; the granted port's ack = 1.
  - The last-grant pointer is updated to the granted port. Go to IDLE.
- Arbitration (round-robin default): if both ports request, the port not granted last wins. If only one port requests, it wins regardless of the pointer.
- Requests are sampled only in IDLE. A request that drops before being granted is simply lost, with no error.
- A requester changing addr/wdata/we after grant has no effect, because the command register holds the values.
- A write does not modify either rdata register.
- When mem_select = 0, mem_rw, mem_address and mem_data_in still reflect the command register, but have no effect on the array.
- There is no wrap-around or arithmetic on addresses. All 2^ADDR_W addresses are legal.

## Timing
- Reset values:
  - State = IDLE.
  - a_ack = b_ack = 0; mem_select = 0; mem_rw = 0.
  - mem_address = 0; mem_data_in = 0.
  - a_rdata = b_rdata = 0.
  - Last-grant pointer = B, so A wins the first contended arbitration.
- Latency: a request seen high at edge N in IDLE gives ACCESS in cycle N+1 and ack in cycle N+2.
- Throughput: one transaction per 3 cycles. Back-to-back requests from both ports alternate A, B, A, ...
- The requester must drop req in the ack cycle, or keep it high to issue a new transaction. A req still high in the IDLE cycle after DONE is treated as a new request.
- Reset asserted mid-transaction:
  - mem_select and ack drop immediately (asynchronous).
  - No ack is issued and the transaction is aborted.
  - A write in progress leaves the addressed word undefined.

## Configuration
- MEM8X8_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, port A always wins when both ports request, and the last-grant pointer is not implemented.
  - Undefined (default): round-robin as described in Operation.

## Structure
- Shared package mem8x8_pkg holds:
  - ADDR_W and DATA_W constants;
  - the state enum (IDLE, ACCESS, DONE);
  - the port index constants PORT_A = 0 and PORT_B = 1.
- One sub-module, rr_arb2: a 2-requester combinational grant with the last-grant pointer input. The top-level FSM holds the pointer register.
- The macro selects the fixed-priority path inside rr_arb2.

## Test plan
- Reset then A write: a_req = 1, a_we = 1, a_addr = 3'd5, a_wdata = 8'hA5 → cycle 1 shows mem_select = 1, mem_rw = 1, mem_address = 5, mem_data_in = A5; cycle 2 shows a_ack = 1; b_ack stays 0.
- A read-back: after the write above, a_req = 1, a_we = 0, a_addr = 5 → a_ack at latency 2 with a_rdata = 8'hA5; mem_rw = 0 during ACCESS.
- Contention: a_req = b_req = 1 held for 12 cycles → ack order A, B, A, B at cycles 2, 5, 8, 11. With MEM8X8_ARB_FIXED_PRIO_EN defined, all four acks go to A.
- Single requester repeat: b_req held high alone, reading addresses 0 then 7 with data preloaded as 8'h11 and 8'h77 → b_ack every 3 cycles; b_rdata = 11, then 77; a_rdata unchanged.
- Command hold: after grant, change a_addr from 2 to 6 in the ACCESS cycle → mem_address stays 2 throughout.
- Reset mid-operation: assert rst_n = 0 during ACCESS → mem_select = 0 and a_ack = 0 immediately; after release, state is IDLE and the first contended grant goes to A.
